// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
//
// Multi-port general-purpose register file. It has N_RD combinational read
// ports, two synchronous write ports (port 1 wins on an address collision),
// optional same-cycle write-to-read forwarding, and a clear sequencer. After
// reset, or on an i_clr request, the sequencer zeroes r1..r(NREG-1), one
// register per clock. r0 always reads as zero.
//
// Ports
//   i_clk     : clock, all state updates on the rising edge
//   i_rst_n   : synchronous active-low reset (restarts the clear sequence)
//   i_clr     : request a full register clear (single-cycle pulse)
//   o_ready   : 1 once the clear sequence is done and writes are accepted
//   i_addr_r  : read addresses, port k at [k*AW +: AW]
//   o_dout_r  : read data, port k at [k*DW +: DW]
//   i_w_en    : write enables, bit j for write port j
//   i_addr_w  : write addresses, port j at [j*AW +: AW]
//   i_din     : write data, port j at [j*DW +: DW]
// ---------------------------------------------------------------------------
module register_file_mp #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int N_RD           = 2,
  parameter int BYPASS         = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_clr,
  output logic                             o_ready,
  input  logic [N_RD*REG_ADDR_WIDTH-1:0]   i_addr_r,
  output logic [N_RD*DATA_WIDTH-1:0]       o_dout_r,
  input  logic [1:0]                       i_w_en,
  input  logic [2*REG_ADDR_WIDTH-1:0]      i_addr_w,
  input  logic [2*DATA_WIDTH-1:0]          i_din
);

  localparam int AW   = REG_ADDR_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int NREG = 1 << AW;

  localparam logic [AW-1:0] CLR_FIRST = AW'(1);
  localparam logic [AW-1:0] CLR_LAST  = AW'(NREG - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          state_q,   state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            ready_q,   ready_d;

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];

  logic [AW-1:0]   waddr0, waddr1;
  logic [DW-1:0]   wdata0, wdata1;
  logic            user_wr_ok;
  logic            wr0_live, wr1_live;

  logic [AW-1:0]   raddr;
  logic [DW-1:0]   rdata;

  assign waddr0 = i_addr_w[0  +: AW];
  assign waddr1 = i_addr_w[AW +: AW];
  assign wdata0 = i_din[0  +: DW];
  assign wdata1 = i_din[DW +: DW];

  // A user write only takes effect in READY, and never in the cycle that
  // requests a clear. Writes to r0 are dropped here, so that neither the
  // storage update nor the forwarding path ever sees them.
  assign user_wr_ok = (state_q == ST_READY) && !i_clr;
  assign wr0_live   = user_wr_ok && i_w_en[0] && (waddr0 != '0);
  assign wr1_live   = user_wr_ok && i_w_en[1] && (waddr1 != '0);

  assign o_ready = ready_q;

  // Control: clear sequencer state machine
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    case (state_q)
      ST_CLEAR: begin
        // The last register is cleared on the same edge that leaves CLEAR,
        // so the sequence takes exactly NREG-1 edges.
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (i_clr) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = CLR_FIRST;
          ready_d   = 1'b0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = CLR_FIRST;
        ready_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= CLR_FIRST;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Storage: clear step or user writes (port 1 applied last so it wins)
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (i_rst_n) begin
      if (state_q == ST_CLEAR) begin
        regs_d[clr_cnt_q] = '0;
      end else begin
        if (wr0_live) regs_d[waddr0] = wdata0;
        if (wr1_live) regs_d[waddr1] = wdata1;
      end
    end
    // r0 is never cleared by the sequencer; pin it so no X is ever stored.
    regs_d[0] = '0;
  end

  // Contents are deliberately not reset; the clear sequencer zeroes them.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NREG; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // Read ports: zero while clearing or for r0; optional forwarding of
  // same-cycle write data, with port 1 taking precedence over port 0.
  always_comb begin
    o_dout_r = '0;
    raddr    = '0;
    rdata    = '0;
    for (int k = 0; k < N_RD; k++) begin
      raddr = i_addr_r[k*AW +: AW];
      rdata = '0;
      if ((state_q == ST_READY) && (raddr != '0)) begin
        rdata = regs_q[raddr];
        if (BYPASS != 0) begin
          if (wr0_live && (waddr0 == raddr)) rdata = wdata0;
          if (wr1_live && (waddr1 == raddr)) rdata = wdata1;
        end
      end
      o_dout_r[k*DW +: DW] = rdata;
    end
  end

endmodule
